// File: rtl/store_trace_fifo.sv
// Store-port observer: captures data-memory stores into a first-word fall-through FIFO,
// counts stores lost to overflow and flags a programmable "pass" store.
module store_trace_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [N-1:0]  dataadr,
    input  logic [N-1:0]  writedata,
    input  logic          match_en,
    input  logic [N-1:0]  match_addr,
    input  logic [N-1:0]  match_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_addr,
    output logic [N-1:0]  out_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [CW-1:0] drop_count,
    output logic          match_pulse,
    output logic          match_hit
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [2*N-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count_q;
    logic           store_req;
    logic           push;
    logic           pop;
    logic           drop;
    logic           match_now;

    // Case-equality keeps an X/Z strobe from being treated as a store.
    always_comb begin
        store_req = (memwrite === 1'b1);
        pop       = out_valid && out_ready;
        push      = store_req && (!full || pop);
        drop      = store_req && full && !pop;
        match_now = store_req && match_en &&
                    (dataadr === match_addr) && (writedata === match_data);
    end

    always_comb begin
        count     = count_q;
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        out_valid = !empty;
        out_addr  = mem[rd_ptr][2*N-1:N];
        out_data  = mem[rd_ptr][N-1:0];
    end

    // Storage array holds data only and is never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {dataadr, writedata};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            match_pulse <= 1'b0;
            match_hit   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
            match_pulse <= match_now;
            if (match_now) begin
                match_hit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_trace_fifo.sv
// Bench for store_trace_fifo: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the FIFO.
module tb_store_trace_fifo;

    localparam int N     = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;
    localparam int MAXD  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          memwrite = 1'b0;
    logic [N-1:0]  dataadr = '0;
    logic [N-1:0]  writedata = '0;
    logic          match_en = 1'b0;
    logic [N-1:0]  match_addr = '0;
    logic [N-1:0]  match_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_addr;
    logic [N-1:0]  out_data;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [CW-1:0] drop_count;
    logic          match_pulse;
    logic          match_hit;

    store_trace_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .match_en(match_en), .match_addr(match_addr),
        .match_data(match_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .count(count), .full(full),
        .empty(empty), .overflow(overflow), .drop_count(drop_count),
        .match_pulse(match_pulse), .match_hit(match_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue of {addr,data} plus sticky flags.
    logic [2*N-1:0] q[$];
    int  m_drop = 0;
    bit  m_ovf = 0;
    bit  m_pulse = 0;
    bit  m_hit = 0;
    bit  m_wr, m_pop, m_match;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_drop = 0; m_ovf = 0; m_pulse = 0; m_hit = 0;
        end else begin
            m_wr    = (memwrite === 1'b1);
            m_pop   = (q.size() > 0) && (out_ready === 1'b1);
            m_match = m_wr && match_en && (dataadr == match_addr) && (writedata == match_data);
            m_pulse = m_match;
            if (m_match) m_hit = 1;
            if (m_pop) void'(q.pop_front());
            if (m_wr) begin
                if (q.size() < DEPTH) q.push_back({dataadr, writedata});
                else begin
                    m_ovf = 1;
                    if (m_drop < MAXD) m_drop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("count", 64'(count), 64'(q.size()));
            check("full", 64'(full), 64'(q.size() == DEPTH));
            check("empty", 64'(empty), 64'(q.size() == 0));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("drop_count", 64'(drop_count), 64'(m_drop));
            check("match_pulse", 64'(match_pulse), 64'(m_pulse));
            check("match_hit", 64'(match_hit), 64'(m_hit));
            if (q.size() > 0) check("head", {out_addr, out_data}, q[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [N-1:0] a, input logic [N-1:0] d, input bit rdy);
        memwrite = 1'b1; dataadr = a; writedata = d; out_ready = rdy;
        tick();
        memwrite = 1'b0; out_ready = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] ea [3];
    logic [N-1:0] ed [3];
    logic [N-1:0] exp_a;

    initial begin
        ea[0] = 84; ea[1] = 88; ea[2] = 92;
        ed[0] = 32'h96; ed[1] = 32'h5; ed[2] = 32'h7;

        #1 reset = 1'b1;
        #3;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        #9 reset = 1'b0;
        chk_en = 1'b1;

        // Three stores held, then drained in order
        for (int i = 0; i < 3; i++) store(ea[i], ed[i], 1'b0);
        check("fill3_count", 64'(count), 64'd3);
        check("fill3_empty", 64'(empty), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("drain3_addr", 64'(out_addr), 64'(ea[i]));
            check("drain3_data", 64'(out_data), 64'(ed[i]));
            pop_one();
        end
        check("drain3_empty", 64'(empty), 64'd1);
        check("drain3_valid", 64'(out_valid), 64'd0);

        // Pass detection
        match_en = 1'b1; match_addr = 84; match_data = 32'h96;
        store(84, 32'h96, 1'b0);
        check("match_pulse_on", 64'(match_pulse), 64'd1);
        check("match_hit_on", 64'(match_hit), 64'd1);
        tick();
        check("match_pulse_off", 64'(match_pulse), 64'd0);
        check("match_hit_held", 64'(match_hit), 64'd1);
        store(84, 32'h95, 1'b0);
        check("nomatch_pulse", 64'(match_pulse), 64'd0);
        match_en = 1'b0;
        pop_one();
        pop_one();
        check("post_match_empty", 64'(empty), 64'd1);

        // Overflow: 8 accepted, 2 dropped
        for (int i = 0; i < 10; i++) store(32'h100 + 4*i, 32'h1000 + i, 1'b0);
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drops", 64'(drop_count), 64'd2);
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_addr", 64'(out_addr), 64'(32'h100 + 4*i));
            pop_one();
        end
        check("ovf_drained", 64'(empty), 64'd1);

        // Store accepted at full when a pop happens in the same cycle
        for (int i = 0; i < 8; i++) store(32'h300 + 4*i, 32'h2000 + i, 1'b0);
        store(32'h380, 32'h3000, 1'b1);
        check("fullpop_count", 64'(count), 64'd8);
        check("fullpop_drops", 64'(drop_count), 64'd2);
        for (int i = 1; i <= 8; i++) begin
            exp_a = (i == 8) ? 32'h380 : 32'h300 + 4*i;
            check("fullpop_drain_addr", 64'(out_addr), 64'(exp_a));
            pop_one();
        end
        check("fullpop_empty", 64'(empty), 64'd1);

        // Push with out_ready while empty: no bypass
        store(32'h200, 32'h55, 1'b1);
        check("empty_push_count", 64'(count), 64'd1);
        check("empty_push_addr", 64'(out_addr), 64'h200);
        check("empty_push_data", 64'(out_data), 64'h55);
        pop_one();

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) store(32'h500 + 4*i, i, 1'b0);
        check("pre_rst_count", 64'(count), 64'd5);
        check("pre_rst_ovf", 64'(overflow), 64'd1);
        check("pre_rst_hit", 64'(match_hit), 64'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_empty", 64'(empty), 64'd1);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ovf", 64'(overflow), 64'd0);
        check("arst_drops", 64'(drop_count), 64'd0);
        check("arst_hit", 64'(match_hit), 64'd0);
        check("arst_pulse", 64'(match_pulse), 64'd0);
        #1 reset = 1'b0;
        store(32'h40, 32'hAB, 1'b0);
        check("post_rst_addr", 64'(out_addr), 64'h40);
        check("post_rst_data", 64'(out_data), 64'hAB);
        check("post_rst_count", 64'(count), 64'd1);

        // Random traffic: first congested (drop saturation), then free-flowing
        match_addr = 32'h10; match_data = 32'h3;
        for (int c = 0; c < 2400; c++) begin
            memwrite  = ($urandom_range(9) < 6);
            dataadr   = ($urandom_range(1) == 0) ? 32'h10 : 32'h14;
            writedata = $urandom_range(3);
            match_en  = $urandom_range(1);
            out_ready = ($urandom_range(9) < ((c < 1200) ? 2 : 7));
            tick();
        end
        memwrite = 1'b0; out_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
